bcd_serial_subtractor: RTL

//  Digit-serial signed subtractor for NDIG-digit packed BCD operands: computes A-B, returns

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_add.sv | 28 ++
 rtl/bcd_serial_subtractor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers for the digit-serial subtractor.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_ADJ  = 4'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } sub_state_t;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_NINE);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with +6 decimal correction; operands arrive pre-complemented as needed.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a_i,
  input  bcd_digit_t b_i,
  input  logic       cin_i,
  output bcd_digit_t sum_o,
  output logic       cout_o
);

  logic [4:0] raw;
  logic [4:0] adj;

  // Binary add, then fold sums above nine back into a decimal digit with carry.
  always_comb begin
    raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
    adj = raw + {1'b0, BCD_ADJ};
    if (raw > 5'd9) begin
      sum_o  = adj[3:0];
      cout_o = 1'b1;
    end else begin
      sum_o  = raw[3:0];
      cout_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial signed BCD subtractor: A-B via ten's-complement add, LSD first,
// with an in-place recomplement pass when the result is negative.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] diff,
  output logic              sign,
  output logic              err
);

  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  sub_state_t        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [4*NDIG-1:0] a_q, a_d;
  logic [4*NDIG-1:0] b_q, b_d;
  logic [4*NDIG-1:0] res_q, res_d;
  logic [4*NDIG-1:0] diff_q, diff_d;
  logic              sign_q, sign_d;
  logic              err_q, err_d;

  logic              ops_ok;
  bcd_digit_t        op_a, op_b, sum;
  logic              cout;

  // Flag any non-decimal digit on the incoming operand pair.
  always_comb begin
    ops_ok = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4])) ops_ok = 1'b0;
    end
  end

  // PASS1 subtracts B from A; PASS2 subtracts the stored result from zero.
  always_comb begin
    if (state_q == PASS1) begin
      op_a = a_q[4*idx_q +: 4];
      op_b = BCD_NINE - b_q[4*idx_q +: 4];
    end else begin
      op_a = '0;
      op_b = BCD_NINE - res_q[4*idx_q +: 4];
    end
  end

  bcd_digit_add u_add (
    .a_i   (op_a),
    .b_i   (op_b),
    .cin_i (carry_q),
    .sum_o (sum),
    .cout_o(cout)
  );

  // Next-state, digit sequencing and result capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    sign_d  = sign_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = 1'b1;
          res_d   = '0;
          if (!ops_ok) begin
            state_d = DONE;
            diff_d  = '0;
            sign_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = PASS1;
          end
        end
      end
      PASS1: begin
        res_d[4*idx_q +: 4] = sum;
        carry_d = cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (cout) begin
            state_d = DONE;
            diff_d  = res_d;
            sign_d  = 1'b0;
            err_d   = 1'b0;
          end else begin
            state_d = PASS2;
            carry_d = 1'b1;
          end
        end
      end
      PASS2: begin
        res_d[4*idx_q +: 4] = sum;
        carry_d = cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
          diff_d  = res_d;
          sign_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign sign      = sign_q;
  assign err       = err_q;

endmodule
